// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data-memory responder for the MEM stage.
// Performs sized RV64 loads/stores on an internal 64-bit word array with a
// fixed latency. It stalls the pipeline while busy and flags misaligned or
// illegal-size requests without touching memory.
module dmem_resp #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned LAT   = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [63:0] addr_i,
   input  logic [63:0] wdata_i,
   input  logic [2:0]  funct3_i,
   output logic        stall_o,
   output logic [63:0] rdata_o,
   output logic        done_o,
   output logic        fault_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Request captured at acceptance; held stable for the whole access.
   logic [AW-1:0] idx_q;
   logic [2:0]    lane_q;
   logic [2:0]    f3_q;
   logic          wr_q;
   logic [63:0]   wdata_q;

   logic [63:0] mem [DEPTH];

   logic        req;
   logic        illegal;
   logic        misaligned;
   logic        accept;
   logic        do_access;
   logic [5:0]  shamt;
   logic [63:0] size_mask;
   logic [63:0] byte_mask;
   logic [63:0] wdata_sh;
   logic [63:0] rword;
   logic [63:0] rword_sh;
   logic [63:0] load_val;

   // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH*8.
   logic unused_addr;
   assign unused_addr = ^addr_i[63:AW+3];

   // Request decode: legality and alignment of the incoming request.
   always_comb begin
      req     = mem_read_i | mem_write_i;
      // A store is selected whenever mem_write_i is high, even if mem_read_i is too.
      illegal = (funct3_i == 3'b111) | (mem_write_i & funct3_i[2]);
      case (funct3_i[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr_i[0];
         2'b10:   misaligned = |addr_i[1:0];
         default: misaligned = |addr_i[2:0];
      endcase
      accept  = (state == IDLE) & req & ~illegal & ~misaligned;
      fault_o = (state == IDLE) & req & (illegal | misaligned);
      stall_o = accept | (state == BUSY);
   end

   // Access datapath: byte masks, shifted store data and extended load data.
   always_comb begin
      shamt = {lane_q, 3'b000};
      case (f3_q[1:0])
         2'b00:   size_mask = 64'h0000_0000_0000_00FF;
         2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = '1;
      endcase
      byte_mask = size_mask << shamt;
      wdata_sh  = wdata_q << shamt;
      rword     = mem[idx_q];
      rword_sh  = rword >> shamt;
      case (f3_q)
         3'b000:  load_val = {{56{rword_sh[7]}},  rword_sh[7:0]};
         3'b001:  load_val = {{48{rword_sh[15]}}, rword_sh[15:0]};
         3'b010:  load_val = {{32{rword_sh[31]}}, rword_sh[31:0]};
         3'b100:  load_val = {56'd0, rword_sh[7:0]};
         3'b101:  load_val = {48'd0, rword_sh[15:0]};
         3'b110:  load_val = {32'd0, rword_sh[31:0]};
         default: load_val = rword_sh;
      endcase
      // Reset at the access edge drops the pending store.
      do_access = (state == BUSY) & (cnt == '0) & ~reset_i;
   end

   // Memory array: read-modify-write of the enabled bytes on a store access.
   always_ff @(posedge clk_i) begin
      if (do_access && wr_q) begin
         mem[idx_q] <= (rword & ~byte_mask) | (wdata_sh & byte_mask);
      end
   end

   // Control FSM: accept, count down the latency, complete and retire.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state   <= IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         f3_q    <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rdata_o <= '0;
         done_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               if (accept) begin
                  idx_q   <= addr_i[AW+2:3];
                  lane_q  <= addr_i[2:0];
                  f3_q    <= funct3_i;
                  wr_q    <= mem_write_i;
                  wdata_q <= wdata_i;
                  cnt     <= CNT_INIT;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  if (!wr_q) begin
                     rdata_o <= load_val;
                  end
                  done_o <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_o <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_o <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed self-checking bench for dmem_resp (DEPTH=512, LAT=2).
module tb_dmem_resp;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [63:0] addr_i;
   logic [63:0] wdata_i;
   logic [2:0]  funct3_i;
   logic        stall_o;
   logic [63:0] rdata_o;
   logic        done_o;
   logic        fault_o;

   int n_checks = 0;
   int n_pass   = 0;

   dmem_resp #(.DEPTH(512), .LAT(2)) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .mem_read_i (mem_read_i),
      .mem_write_i(mem_write_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .funct3_i   (funct3_i),
      .stall_o    (stall_o),
      .rdata_o    (rdata_o),
      .done_o     (done_o),
      .fault_o    (fault_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
   endtask

   task automatic clear_req();
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      addr_i      = '0;
      wdata_i     = '0;
      funct3_i    = '0;
   endtask

   // Issue one legal request (called #1 after a rising edge), hold it until done_o,
   // count stall cycles, optionally check the returned data.
   task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                         input logic [63:0] d, input logic [2:0] f3, input string tag,
                         input logic chk_data, input logic [63:0] exp_data);
      int          stalls;
      bit          seen;
      logic [63:0] got;
      stalls = 0;
      seen   = 1'b0;
      got    = '0;
      mem_read_i  = rd;
      mem_write_i = wr;
      addr_i      = a;
      wdata_i     = d;
      funct3_i    = f3;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (stall_o === 1'b1) stalls++;
         if (done_o === 1'b1) begin
            seen = 1'b1;
            got  = rdata_o;
            clear_req();
         end
      end
      if (!seen) clear_req();
      check($sformatf("%s_done", tag), 64'(seen), 64'd1);
      check($sformatf("%s_stall", tag), 64'(stalls), 64'd3);
      if (chk_data) check($sformatf("%s_data", tag), got, exp_data);
      @(posedge clk); #1;
   endtask

   // Present a faulting request for two cycles; it must never be accepted.
   task automatic fault_case(input logic rd, input logic wr, input logic [63:0] a,
                             input logic [2:0] f3, input string tag);
      mem_read_i  = rd;
      mem_write_i = wr;
      addr_i      = a;
      wdata_i     = 64'hDEAD_BEEF_DEAD_BEEF;
      funct3_i    = f3;
      #1;
      check($sformatf("%s_fault", tag), 64'(fault_o), 64'd1);
      check($sformatf("%s_nostall", tag), 64'(stall_o), 64'd0);
      @(posedge clk); #1;
      check($sformatf("%s_idle", tag), 64'(fault_o), 64'd1);
      check($sformatf("%s_nodone", tag), 64'(done_o), 64'd0);
      clear_req();
      @(posedge clk); #1;
   endtask

   initial begin
      reset_i = 1'b1;
      clear_req();
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_stall", 64'(stall_o), 64'd0);
      check("rst_fault", 64'(fault_o), 64'd0);
      check("rst_rdata", rdata_o, 64'd0);

      // Store then full-word load.
      access(1'b0, 1'b1, 64'h10, 64'h8877665544332211, 3'b011, "sd10", 1'b0, '0);
      access(1'b1, 1'b0, 64'h10, '0, 3'b011, "ld10", 1'b1, 64'h8877665544332211);

      // Sized loads from that word.
      access(1'b1, 1'b0, 64'h17, '0, 3'b000, "lb17", 1'b1, 64'hFFFFFFFFFFFFFF88);
      access(1'b1, 1'b0, 64'h17, '0, 3'b100, "lbu17", 1'b1, 64'h0000000000000088);
      access(1'b1, 1'b0, 64'h16, '0, 3'b001, "lh16", 1'b1, 64'hFFFFFFFFFFFF8877);
      access(1'b1, 1'b0, 64'h12, '0, 3'b101, "lhu12", 1'b1, 64'h0000000000004433);
      access(1'b1, 1'b0, 64'h14, '0, 3'b010, "lw14", 1'b1, 64'hFFFFFFFF88776655);
      access(1'b1, 1'b0, 64'h14, '0, 3'b110, "lwu14", 1'b1, 64'h0000000088776655);

      // Partial store; rdata_o keeps the last load value through a store.
      access(1'b0, 1'b1, 64'h11, 64'h00000000000000AA, 3'b000, "sb11", 1'b1, 64'h0000000088776655);
      access(1'b1, 1'b0, 64'h10, '0, 3'b011, "ld10_sb", 1'b1, 64'h887766554433AA11);

      // Faults: misaligned load, misaligned store, illegal size, unsigned store.
      fault_case(1'b1, 1'b0, 64'h12, 3'b010, "lw12");
      fault_case(1'b0, 1'b1, 64'h14, 3'b011, "sd14");
      fault_case(1'b1, 1'b0, 64'h10, 3'b111, "f3_111");
      fault_case(1'b0, 1'b1, 64'h10, 3'b100, "sbu");
      access(1'b1, 1'b0, 64'h10, '0, 3'b011, "ld10_flt", 1'b1, 64'h887766554433AA11);

      // Reset during the first BUSY cycle of a store drops it.
      access(1'b0, 1'b1, 64'h20, 64'h5, 3'b011, "sd20_pre", 1'b0, '0);
      access(1'b1, 1'b0, 64'h20, '0, 3'b011, "ld20_pre", 1'b1, 64'h5);
      mem_write_i = 1'b1;
      addr_i      = 64'h20;
      wdata_i     = 64'h1;
      funct3_i    = 3'b011;
      @(posedge clk); #1;
      check("rstmid_busy", 64'(stall_o), 64'd1);
      reset_i = 1'b1;
      clear_req();
      @(posedge clk); #1;
      reset_i = 1'b0;
      check("rstmid_done", 64'(done_o), 64'd0);
      check("rstmid_stall", 64'(stall_o), 64'd0);
      check("rstmid_fault", 64'(fault_o), 64'd0);
      check("rstmid_rdata", rdata_o, 64'd0);
      access(1'b1, 1'b0, 64'h20, '0, 3'b011, "ld20_post", 1'b1, 64'h5);

      // Address wrap plus read/write priority: both high is a store to word 2.
      access(1'b1, 1'b1, 64'h1010, 64'h0123456789ABCDEF, 3'b011, "sd1010", 1'b1, 64'h5);
      access(1'b1, 1'b0, 64'h10, '0, 3'b011, "ld10_wrap", 1'b1, 64'h0123456789ABCDEF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Multi-cycle data-memory responder for the MEM stage of the pipeline. It accepts load and store requests qualified by the decoder's `mem_read`/`mem_write` controls and performs sized RV64 accesses on an internal 64-bit word array with a fixed access latency. It holds the pipeline with `stall_o` until the access completes. On loads it returns sign- or zero-extended data, and it flags misaligned or illegal-size accesses without touching memory.

## Interface
Parameters:
- `DEPTH`, 512: number of 64-bit words; power of two, ≥ 2.
- `LAT`, 2: access latency in cycles; ≥ 1.

Ports:
- `clk_i` in 1: clock; all state changes on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `mem_read_i` in 1: load request from MEM-stage pipeline register.
- `mem_write_i` in 1: store request from MEM-stage pipeline register.
- `addr_i` in 64: byte address (ALU result).
- `wdata_i` in 64: store data (rs2); low bytes used per size.
- `funct3_i` in 3: access size/sign. 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- `stall_o` out 1: freeze PC, IF/ID, ID/EX and EX/MEM registers.
- `rdata_o` out 64: extended load data; valid while `done_o`=1 for a load.
- `done_o` out 1: one-cycle completion pulse.
- `fault_o` out 1: one-cycle misaligned/illegal-size indication.

## Operation
- Request: `req = mem_read_i | mem_write_i`. If both are high, the request is a store.
- Word index is `addr_i[log2(DEPTH)+2:3]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH*8`. Byte lane is `addr_i[2:0]`.
- Alignment check: H requires `addr[0]`=0; W requires `addr[1:0]`=0; D requires `addr[2:0]`=0. B is always aligned.
- Illegal requests are funct3=111 on any request, or funct3 100/101/110 on a store. Illegal or misaligned requests cause no access.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with a legal, aligned req: capture addr, wdata, funct3 and direction; load counter with `LAT-1`; go to BUSY.
  - IDLE with a faulting req: `fault_o`=1 combinationally, no stall, stay in IDLE.
  - IDLE with no req: stay in IDLE.
  - BUSY with counter ≠ 0: decrement and stay in BUSY.
  - BUSY with counter = 0: perform the access at this edge and go to DONE.
    - Store: read-modify-write of the addressed word, replacing only the enabled bytes.
    - Load: extract the sized field at the byte lane, extend it, and register it into `rdata_o`.
  - DONE: `done_o`=1. Go to IDLE unconditionally. Requests seen in DONE are ignored, because they belong to the instruction now retiring.
- `stall_o = (IDLE & req & legal & aligned) | BUSY`. It is low in DONE.
- Extension: B/H/W sign-extend from bit 7/15/31. BU/HU/WU zero-extend. D passes through unchanged.
- `rdata_o` holds its last load value until the next load completes. Stores do not change it.
- Memory contents are not reset and start undefined.

## Timing
- Reset values: state IDLE, counter 0, `rdata_o`=0, `done_o`=0, `stall_o`=0, `fault_o`=0.
- Reset asserted mid-operation returns the FSM to IDLE at that edge. A pending store is dropped and the array is left unmodified.
- For a legal request first presented in cycle T:
  - `stall_o`=1 in cycles T through T+LAT.
  - The access occurs at the end of cycle T+LAT.
  - `done_o`=1 and load data are valid in cycle T+LAT+1.
- Total occupancy is LAT+2 cycles. With back-to-back requests, the next request is accepted in the cycle after DONE.
- A store followed immediately by a load to the same word returns the newly written bytes, since the store completes before the load is accepted.
- `fault_o` is combinational from the inputs in IDLE only. It is never asserted in BUSY or DONE.

## Test plan
- Store then load (LAT=2): SD addr 0x10, data 0x8877665544332211. Then LD addr 0x10 → `stall_o` high 3 cycles each; on the load's `done_o`, `rdata_o`=0x8877665544332211.
- Sized loads from that word:
  - LB addr 0x17 → 0xFFFFFFFFFFFFFF88.
  - LBU addr 0x17 → 0x88.
  - LH addr 0x16 → 0xFFFFFFFFFFFF8877.
  - LWU addr 0x14 → 0x88776655.
- Partial store: SB addr 0x11, data 0xAA, then LD 0x10 → 0x887766554433AA11. Other bytes are unchanged.
- Faults:
  - LW addr 0x12 → `fault_o`=1 same cycle, `stall_o`=0, state stays IDLE.
  - SD addr 0x14 → fault, and a following LD 0x10 returns the unchanged word.
  - funct3=111 → fault.
- Reset mid-store: SD addr 0x20, data 0x1, with reset pulsed in the first BUSY cycle → all outputs 0 next cycle. The word at 0x20 keeps its prior value (preload 0x5; LD returns 0x5).
- Wrap and priority (DEPTH=512): SD addr 0x1010 aliases word 2 (0x10); LD 0x10 returns the stored value. Both `mem_read_i` and `mem_write_i` high → performs a store.
